// File: rtl/sram_uart_dump_if.sv
// sram_uart_dump_if: dump control, SRAM read port and UART/status signals of sram_uart_dump.
interface sram_uart_dump_if;
  logic Start;
  logic [17:0] Base_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic UART_TX_O;
  logic Busy;
  logic Done;
  modport master (output Start, Base_address, Word_count, SRAM_read_data,
                  input SRAM_address, UART_TX_O, Busy, Done);
  modport slave (input Start, Base_address, Word_count, SRAM_read_data,
                 output SRAM_address, UART_TX_O, Busy, Done);
endinterface

// File: rtl/sram_uart_dump.sv
// sram_uart_dump: streams SRAM words over 8N1 UART, high byte first.
// Define PPM_HEADER_EN to prefix each dump with a 15-byte PPM header.
module sram_uart_dump #(
  parameter int CLOCKS_PER_BIT = 434,
  parameter int SRAM_READ_LATENCY = 2
) (
  input logic Clock_50,
  input logic Resetn,
  sram_uart_dump_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_FETCH, S_SEND_HI, S_SEND_LO, S_FINISH} state_t;
  localparam logic [15:0] BIT_LAST = 16'(CLOCKS_PER_BIT - 1);
  localparam logic [15:0] FETCH_LAST = 16'(SRAM_READ_LATENCY);
  state_t state, nxt;
  logic [17:0] base, count, idx, addr;
  logic [15:0] hold, cnt;
  logic [3:0] bit_cnt;
  logic [7:0] tx_byte;
  logic [9:0] frame;
  logic sending, baud_end, byte_end, fetch_end, last_word;
`ifdef PPM_HEADER_EN
  localparam logic [7:0] HDR [16] = '{8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20, 8'h32,
                                      8'h34, 8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A, 8'h00};
  logic [3:0] hdr_idx;
  logic hdr_end;
  assign hdr_end = byte_end && hdr_idx == 4'd14;
  assign sending = state inside {S_HEADER, S_SEND_HI, S_SEND_LO};
  assign tx_byte = state == S_SEND_HI ? hold[15:8] : state == S_SEND_LO ? hold[7:0] : HDR[hdr_idx];
`else
  assign sending = state inside {S_SEND_HI, S_SEND_LO};
  assign tx_byte = state == S_SEND_HI ? hold[15:8] : hold[7:0];
`endif
  assign baud_end = cnt == BIT_LAST;
  assign byte_end = sending && baud_end && bit_cnt == 4'd9;
  assign fetch_end = state == S_FETCH && cnt == FETCH_LAST;
  assign last_word = idx + 18'd1 == count;
  // Start bit at index 0, stop bit at index 9, data LSB first in between.
  assign frame = {1'b1, tx_byte, 1'b0};
  assign bus.UART_TX_O = sending ? frame[bit_cnt] : 1'b1;
  assign bus.Busy = state != S_IDLE && state != S_FINISH;
  assign bus.Done = state == S_FINISH;
  assign bus.SRAM_address = addr;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (bus.Start)
`ifdef PPM_HEADER_EN
        nxt = S_HEADER;
      S_HEADER: if (hdr_end) nxt = count == '0 ? S_FINISH : S_FETCH;
`else
        nxt = bus.Word_count == '0 ? S_FINISH : S_FETCH;
`endif
      S_FETCH: if (fetch_end) nxt = S_SEND_HI;
      S_SEND_HI: if (byte_end) nxt = S_SEND_LO;
      S_SEND_LO: if (byte_end) nxt = last_word ? S_FINISH : S_FETCH;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge Clock_50 or negedge Resetn)
    if (!Resetn) begin
      state <= S_IDLE;
      base <= '0;
      count <= '0;
      idx <= '0;
      addr <= '0;
      hold <= '0;
      cnt <= '0;
      bit_cnt <= '0;
`ifdef PPM_HEADER_EN
      hdr_idx <= '0;
`endif
    end else begin
      state <= nxt;
      // One counter times both the fetch wait and each bit period.
      cnt <= (state == S_IDLE || nxt != state || (sending && baud_end)) ? '0 : cnt + 16'd1;
      bit_cnt <= (!sending || byte_end) ? '0 : baud_end ? bit_cnt + 4'd1 : bit_cnt;
`ifdef PPM_HEADER_EN
      hdr_idx <= state == S_IDLE ? '0 : (state == S_HEADER && byte_end) ? hdr_idx + 4'd1 : hdr_idx;
`endif
      if (state == S_IDLE && bus.Start) begin
        base <= bus.Base_address;
        count <= bus.Word_count;
        addr <= bus.Base_address;
        idx <= '0;
      end
      if (fetch_end) hold <= bus.SRAM_read_data;
      if (state == S_SEND_LO && byte_end) begin
        idx <= idx + 18'd1;
        if (!last_word) addr <= base + idx + 18'd1;
      end
    end
endmodule
